// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status into the controller, stage enables/flushes out.
// The controller side uses the slave modport; the pipeline side uses master.
interface pipeline_hazard_ctrl_if;
    logic       ihit;
    logic       dhit;
    logic       dmem_req;
    logic       idex_dREN;
    logic [4:0] idex_wsel;
    logic [4:0] ifid_rs;
    logic [4:0] ifid_rt;
    logic       ifid_uses_rt;
    logic       redirect_ex;
    logic       exmem_halt;

    logic       pc_en;
    logic       ifid_enable;
    logic       idex_enable;
    logic       exmem_enable;
    logic       memwb_enable;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_flush;
    logic       memwb_flush;
    logic       halt;

    modport master (
        output ihit, dhit, dmem_req, idex_dREN, idex_wsel, ifid_rs, ifid_rt,
               ifid_uses_rt, redirect_ex, exmem_halt,
        input  pc_en, ifid_enable, idex_enable, exmem_enable, memwb_enable,
               ifid_flush, idex_flush, exmem_flush, memwb_flush, halt
    );

    modport slave (
        input  ihit, dhit, dmem_req, idex_dREN, idex_wsel, ifid_rs, ifid_rt,
               ifid_uses_rt, redirect_ex, exmem_halt,
        output pc_en, ifid_enable, idex_enable, exmem_enable, memwb_enable,
               ifid_flush, idex_flush, exmem_flush, memwb_flush, halt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: D-cache freeze, load-use, I-miss,
// EX redirect and halt drain. Optional statistics counters under `HAZARD_STATS_EN.
//
// state     | meaning
// RUN       | normal issue, hazards resolved combinationally
// DMEM_WAIT | D-cache access outstanding, whole pipeline frozen
// DRAIN     | halt seen in MEM, letting older instructions retire through MEM/WB
// HALTED    | pipeline stopped, left only by reset
module pipeline_hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 1
`ifdef HAZARD_STATS_EN
    ,
    parameter int unsigned STAT_W = 32
`endif
) (
    input  logic                   CLK,
    input  logic                   nRST,
    pipeline_hazard_ctrl_if.slave  hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0]      stall_cnt,
    output logic [STAT_W-1:0]      flush_cnt,
    output logic [STAT_W-1:0]      miss_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DMEM_WAIT = 2'd1,
        DRAIN     = 2'd2,
        HALTED    = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] drain_cnt, drain_cnt_nxt;

    logic load_use, dmiss, drain_adv, redirect_taken;
    logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
    logic ifid_fl_c, idex_fl_c, exmem_fl_c, memwb_fl_c, halt_c;

    assign load_use = hz.idex_dREN && (hz.idex_wsel != 5'd0) &&
                      ((hz.idex_wsel == hz.ifid_rs) ||
                       (hz.ifid_uses_rt && (hz.idex_wsel == hz.ifid_rt)));
    assign dmiss     = hz.dmem_req && !hz.dhit;
    assign drain_adv = hz.dhit || !hz.dmem_req;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= RUN;
            drain_cnt <= 3'd0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        drain_cnt_nxt  = drain_cnt;
        redirect_taken = 1'b0;
        pc_en_c        = 1'b0;
        ifid_en_c      = 1'b0;
        idex_en_c      = 1'b0;
        exmem_en_c     = 1'b0;
        memwb_en_c     = 1'b0;
        ifid_fl_c      = 1'b0;
        idex_fl_c      = 1'b0;
        exmem_fl_c     = 1'b0;
        memwb_fl_c     = 1'b0;
        halt_c         = 1'b0;

        if (!nRST) begin
            // Bubbles everywhere while reset is held
            ifid_fl_c  = 1'b1;
            idex_fl_c  = 1'b1;
            exmem_fl_c = 1'b1;
            memwb_fl_c = 1'b1;
        end else begin
            unique case (state)
                RUN, DMEM_WAIT: begin
                    if (dmiss) begin
                        state_nxt = DMEM_WAIT;
                    end else begin
                        state_nxt  = RUN;
                        exmem_en_c = 1'b1;
                        memwb_en_c = 1'b1;
                        if (hz.redirect_ex) begin
                            // Stale fetch is abandoned, so a pending I-miss does not hold the PC
                            pc_en_c        = 1'b1;
                            ifid_fl_c      = 1'b1;
                            idex_fl_c      = 1'b1;
                            redirect_taken = 1'b1;
                        end else if (load_use) begin
                            idex_fl_c = 1'b1;
                        end else if (!hz.ihit) begin
                            ifid_fl_c = 1'b1;
                            idex_en_c = 1'b1;
                        end else begin
                            pc_en_c   = 1'b1;
                            ifid_en_c = 1'b1;
                            idex_en_c = 1'b1;
                        end
                        if (hz.exmem_halt) begin
                            state_nxt     = DRAIN;
                            drain_cnt_nxt = 3'(DRAIN_CYCLES);
                        end
                    end
                end
                DRAIN: begin
                    ifid_fl_c  = 1'b1;
                    idex_fl_c  = 1'b1;
                    exmem_fl_c = 1'b1;
                    memwb_en_c = drain_adv;
                    if (drain_adv) begin
                        if (drain_cnt <= 3'd1) begin
                            state_nxt     = HALTED;
                            drain_cnt_nxt = 3'd0;
                        end else begin
                            drain_cnt_nxt = drain_cnt - 3'd1;
                        end
                    end
                end
                HALTED: begin
                    halt_c = 1'b1;
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    assign hz.pc_en        = pc_en_c;
    assign hz.ifid_enable  = ifid_en_c;
    assign hz.idex_enable  = idex_en_c;
    assign hz.exmem_enable = exmem_en_c;
    assign hz.memwb_enable = memwb_en_c;
    assign hz.ifid_flush   = ifid_fl_c;
    assign hz.idex_flush   = idex_fl_c;
    assign hz.exmem_flush  = exmem_fl_c;
    assign hz.memwb_flush  = memwb_fl_c;
    assign hz.halt         = halt_c;

`ifdef HAZARD_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = '1;
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

    logic in_run;
    assign in_run = (state == RUN) || (state == DMEM_WAIT);

    // Counters saturate; nothing counts outside RUN/DMEM_WAIT so HALTED freezes them
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            miss_cnt  <= '0;
        end else begin
            if (in_run && !pc_en_c && (stall_cnt != STAT_MAX))
                stall_cnt <= stall_cnt + STAT_ONE;
            if (redirect_taken && (flush_cnt != STAT_MAX))
                flush_cnt <= flush_cnt + STAT_ONE;
            if ((state == DMEM_WAIT) && (miss_cnt != STAT_MAX))
                miss_cnt <= miss_cnt + STAT_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: table-driven combinational vectors plus hand sequences
// for D-miss freeze, halt drain and reset recovery, checked through an expectation queue.
module tb_pipeline_hazard_ctrl;
    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl_if bus ();

`ifdef HAZARD_STATS_EN
    logic [3:0] stall_cnt, flush_cnt, miss_cnt;
    pipeline_hazard_ctrl #(.DRAIN_CYCLES(1), .STAT_W(4)) dut (
        .CLK(CLK), .nRST(nRST), .hz(bus),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .miss_cnt(miss_cnt)
    );
`else
    pipeline_hazard_ctrl #(.DRAIN_CYCLES(1)) dut (
        .CLK(CLK), .nRST(nRST), .hz(bus)
    );
`endif

    // Bit order: {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    //             ifid_fl, idex_fl, exmem_fl, memwb_fl, halt}
    localparam logic [9:0] E_NORMAL  = 10'b1111100000;
    localparam logic [9:0] E_REDIR   = 10'b1001111000;
    localparam logic [9:0] E_LDUSE   = 10'b0001101000;
    localparam logic [9:0] E_IMISS   = 10'b0011110000;
    localparam logic [9:0] E_FREEZE  = 10'b0000000000;
    localparam logic [9:0] E_DRADV   = 10'b0000111100;
    localparam logic [9:0] E_DRSTALL = 10'b0000011100;
    localparam logic [9:0] E_HALTED  = 10'b0000000001;
    localparam logic [9:0] E_RESET   = 10'b0000011110;

    typedef struct {
        logic       ihit, dhit, dmem_req, idex_dren;
        logic [4:0] idex_wsel, ifid_rs, ifid_rt;
        logic       uses_rt, redirect_ex, exmem_halt;
    } in_t;

    typedef struct {
        in_t        i;
        logic [9:0] e;
        string      nm;
    } vec_t;

    typedef struct {
        string      nm;
        logic [9:0] e;
    } sb_t;

    sb_t  sb[$];
    vec_t tbl[12];
    int   checks = 0;
    int   errors = 0;

    logic [9:0] act;
    assign act = {bus.pc_en, bus.ifid_enable, bus.idex_enable, bus.exmem_enable,
                  bus.memwb_enable, bus.ifid_flush, bus.idex_flush, bus.exmem_flush,
                  bus.memwb_flush, bus.halt};

    function automatic in_t mk(input logic ihit, input logic dhit, input logic dreq,
                               input logic dren, input logic [4:0] wsel,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic urt, input logic redir, input logic hlt);
        in_t r;
        r.ihit = ihit; r.dhit = dhit; r.dmem_req = dreq; r.idex_dren = dren;
        r.idex_wsel = wsel; r.ifid_rs = rs; r.ifid_rt = rt;
        r.uses_rt = urt; r.redirect_ex = redir; r.exmem_halt = hlt;
        return r;
    endfunction

    task automatic drive(input in_t v);
        bus.ihit         = v.ihit;
        bus.dhit         = v.dhit;
        bus.dmem_req     = v.dmem_req;
        bus.idex_dREN    = v.idex_dren;
        bus.idex_wsel    = v.idex_wsel;
        bus.ifid_rs      = v.ifid_rs;
        bus.ifid_rt      = v.ifid_rt;
        bus.ifid_uses_rt = v.uses_rt;
        bus.redirect_ex  = v.redirect_ex;
        bus.exmem_halt   = v.exmem_halt;
    endtask

    task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Drive one cycle's inputs, queue the expectation, compare mid-cycle, then cross the edge
    task automatic step(input in_t v, input logic [9:0] e, input string nm);
        sb_t s;
        drive(v);
        sb.push_back('{nm, e});
        @(negedge CLK);
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            s = sb.pop_front();
            checks++;
            if (act !== s.e) begin
                errors++;
                $display("FAIL %s: got %b expected %b", s.nm, act, s.e);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), E_RESET, "reset_outputs");
        nRST = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        in_t idle;
        idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        tbl[0]  = '{mk(1, 0, 0, 0, 5'd0, 5'd1, 5'd2, 1, 0, 0), E_NORMAL, "normal"};
        tbl[1]  = '{mk(1, 0, 0, 1, 5'd8, 5'd8, 5'd2, 0, 0, 0), E_LDUSE,  "loaduse_rs"};
        tbl[2]  = '{mk(1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0), E_NORMAL, "loaduse_r0"};
        tbl[3]  = '{mk(1, 0, 0, 1, 5'd9, 5'd3, 5'd9, 1, 0, 0), E_LDUSE,  "loaduse_rt"};
        tbl[4]  = '{mk(1, 0, 0, 1, 5'd9, 5'd3, 5'd9, 0, 0, 0), E_NORMAL, "rt_unused"};
        tbl[5]  = '{mk(1, 0, 0, 0, 5'd8, 5'd8, 5'd8, 1, 0, 0), E_NORMAL, "no_load"};
        tbl[6]  = '{mk(0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0), E_IMISS,  "imiss"};
        tbl[7]  = '{mk(0, 0, 0, 1, 5'd8, 5'd8, 5'd2, 0, 0, 0), E_LDUSE,  "loaduse_over_imiss"};
        tbl[8]  = '{mk(0, 0, 0, 1, 5'd8, 5'd8, 5'd2, 0, 1, 0), E_REDIR,  "redir_over_all"};
        tbl[9]  = '{mk(1, 1, 1, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0), E_NORMAL, "dhit_normal"};
        tbl[10] = '{mk(1, 1, 1, 0, 5'd0, 5'd1, 5'd2, 0, 1, 0), E_REDIR,  "dhit_redirect"};
        tbl[11] = '{mk(1, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 1, 0), E_REDIR,  "redirect"};

        drive(idle);
        nRST = 1'b0;
        @(posedge CLK);
        #1;
        do_reset();
`ifdef HAZARD_STATS_EN
        check_val("stall_cnt_reset", 32'(stall_cnt), 32'd0);
        check_val("miss_cnt_reset",  32'(miss_cnt),  32'd0);
`endif

        for (int k = 0; k < 12; k++)
            step(tbl[k].i, tbl[k].e, tbl[k].nm);

        // Load-use lasts one cycle once the bubble reaches EX
        step(mk(1, 0, 0, 1, 5'd8, 5'd8, 5'd2, 0, 0, 0), E_LDUSE,  "lu_seq_stall");
        step(mk(1, 0, 0, 0, 5'd0, 5'd8, 5'd2, 0, 0, 0), E_NORMAL, "lu_seq_resume");

        // D-miss freeze holds off a pending redirect
        for (int k = 0; k < 3; k++)
            step(mk(1, 0, 1, 0, 5'd0, 5'd1, 5'd2, 0, 1, 0), E_FREEZE, "dmiss_freeze");
        step(mk(1, 1, 1, 0, 5'd0, 5'd1, 5'd2, 0, 1, 0), E_REDIR,  "dmiss_release_redir");
        step(idle, E_NORMAL, "after_dmiss");

        // Halt drain with DRAIN_CYCLES=1
        step(mk(1, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 1), E_NORMAL, "halt_enter");
        step(mk(1, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 1, 0), E_DRADV,  "drain_adv_redir_ignored");
        step(idle, E_HALTED, "halted");
        step(mk(1, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 1, 0), E_HALTED, "halted_redirect");
        step(mk(0, 0, 1, 1, 5'd8, 5'd8, 5'd2, 0, 0, 0), E_HALTED, "halted_sticky");

        // Reset in the middle of a stalled drain
        do_reset();
        step(mk(1, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 1), E_NORMAL,  "halt_enter2");
        step(mk(1, 0, 1, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0), E_DRSTALL, "drain_stall");
        step(mk(1, 0, 1, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0), E_DRSTALL, "drain_stall_held");
        nRST = 1'b0;
        step(mk(1, 0, 1, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0), E_RESET,   "reset_mid_drain");
        nRST = 1'b1;
        step(idle, E_NORMAL, "run_after_reset");

`ifdef HAZARD_STATS_EN
        do_reset();
        for (int k = 0; k < 3; k++)
            step(mk(1, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 1, 0), E_REDIR, "stat_redirect");
        check_val("flush_cnt_3", 32'(flush_cnt), 32'd3);
        check_val("stall_cnt_0", 32'(stall_cnt), 32'd0);
        for (int k = 0; k < 20; k++)
            step(mk(1, 0, 1, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0), E_FREEZE, "stat_miss");
        check_val("miss_cnt_sat",  32'(miss_cnt),  32'd15);
        check_val("stall_cnt_sat", 32'(stall_cnt), 32'd15);
        check_val("flush_cnt_hold", 32'(flush_cnt), 32'd3);
`endif

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
